// File: rtl/morse_pkg.sv
// Morse assembler shared types: ASCII constants, FSM state, lookup.
// morse_lookup maps (count, pattern) to ASCII; first element is the MSB.
package morse_pkg;

  localparam logic [7:0] CH_SPACE   = 8'h20;
  localparam logic [7:0] CH_UNKNOWN = 8'h3F;

  typedef enum logic [1:0] {
    IDLE,
    PUSH_CHAR,
    PUSH_SPACE
  } state_t;

  function automatic logic [7:0] morse_lookup(
    input logic [2:0] cnt,
    input logic [4:0] sym
  );
    logic [7:0] c;
    c = CH_UNKNOWN;
    case (cnt)
      3'd1: c = sym[0] ? 8'h54 : 8'h45;
      3'd2: begin
        case (sym[1:0])
          2'b00:   c = 8'h49;
          2'b01:   c = 8'h41;
          2'b10:   c = 8'h4E;
          default: c = 8'h4D;
        endcase
      end
      3'd3: begin
        case (sym[2:0])
          3'b000:  c = 8'h53;
          3'b001:  c = 8'h55;
          3'b010:  c = 8'h52;
          3'b011:  c = 8'h57;
          3'b100:  c = 8'h44;
          3'b101:  c = 8'h4B;
          3'b110:  c = 8'h47;
          default: c = 8'h4F;
        endcase
      end
      3'd4: begin
        case (sym[3:0])
          4'b0000: c = 8'h48;
          4'b0001: c = 8'h56;
          4'b0010: c = 8'h46;
          4'b0100: c = 8'h4C;
          4'b0110: c = 8'h50;
          4'b0111: c = 8'h4A;
          4'b1000: c = 8'h42;
          4'b1001: c = 8'h58;
          4'b1010: c = 8'h43;
          4'b1011: c = 8'h59;
          4'b1100: c = 8'h5A;
          4'b1101: c = 8'h51;
          default: c = CH_UNKNOWN;
        endcase
      end
      3'd5: begin
        case (sym)
          5'b11111: c = 8'h30;
          5'b01111: c = 8'h31;
          5'b00111: c = 8'h32;
          5'b00011: c = 8'h33;
          5'b00001: c = 8'h34;
          5'b00000: c = 8'h35;
          5'b10000: c = 8'h36;
          5'b11000: c = 8'h37;
          5'b11100: c = 8'h38;
          5'b11110: c = 8'h39;
          default:  c = CH_UNKNOWN;
        endcase
      end
      default: c = CH_UNKNOWN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// First-word-fall-through character FIFO; head reads 0x00 when empty.
// Ports: wr_en/wr_data, rd_en/rd_data, empty, full, level (0..DEPTH).
module morse_char_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_rd;
  logic          do_wr;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_LVL);
  assign level = cnt;

  // A pop in the same cycle frees the slot a full write needs.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/morse_char_assembler.sv
// Turns closed Morse element patterns into ASCII (plus word spaces).
// In: symbol/symbol_count, lg/wg, char_ready. Out: char stream, level.
module morse_char_assembler
  import morse_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [4:0]    symbol,
  input  logic [2:0]    symbol_count,
  input  logic          lg,
  input  logic          wg,
  output logic [7:0]    char_data,
  output logic          char_valid,
  input  logic          char_ready,
  output logic          overflow,
  output logic [AW:0]   fifo_level
);

  state_t      state;
  logic [4:0]  sh_sym;
  logic [2:0]  sh_cnt;
  logic [7:0]  pend_char;
  logic        pend_space;
  logic        last_was_space;
  logic        have_sym;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic        empty;
  logic        full;

  assign have_sym   = (sh_cnt != 3'd0);
  assign wr_en      = (state == PUSH_CHAR) ||
                      (state == PUSH_SPACE);
  assign wr_data    = (state == PUSH_CHAR) ? pend_char : CH_SPACE;
  assign char_valid = !empty;
  assign rd_en      = char_valid && char_ready;

  // Upstream clears symbol with the gap pulse, so decode the shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      sh_sym         <= '0;
      sh_cnt         <= '0;
      pend_char      <= '0;
      pend_space     <= 1'b0;
      last_was_space <= 1'b1;
      overflow       <= 1'b0;
    end else begin
      sh_sym <= symbol;
      sh_cnt <= symbol_count;
      if (wr_en && full && !rd_en) overflow <= 1'b1;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            wg && have_sym: begin
              pend_char  <= morse_lookup(sh_cnt, sh_sym);
              pend_space <= 1'b1;
              state      <= PUSH_CHAR;
            end
            wg && !have_sym && !last_was_space: begin
              state <= PUSH_SPACE;
            end
            lg && !wg && have_sym: begin
              pend_char  <= morse_lookup(sh_cnt, sh_sym);
              pend_space <= 1'b0;
              state      <= PUSH_CHAR;
            end
            default: ;
          endcase
        end
        PUSH_CHAR: begin
          last_was_space <= 1'b0;
          state <= pend_space ? PUSH_SPACE : IDLE;
        end
        PUSH_SPACE: begin
          last_was_space <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  morse_char_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (char_data),
    .empty   (empty),
    .full    (full),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_morse_char_assembler.sv
// Bench for morse_char_assembler: directed steps then random traffic
// checked against a string-table Morse model and an expected queue.
module tb_morse_char_assembler;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [4:0]    symbol = '0;
  logic [2:0]    symbol_count = '0;
  logic          lg = 1'b0;
  logic          wg = 1'b0;
  logic          char_ready = 1'b0;
  logic [7:0]    char_data;
  logic          char_valid;
  logic          overflow;
  logic [AW:0]   fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en     = 1'b0;
  bit rand_ready = 1'b0;
  bit last_space = 1'b1;
  logic [7:0] q[$];
  logic [7:0] exp_c[DEPTH+1];

  string codes[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
    "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
    "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
    "-.--", "--..", "-----", ".----", "..---", "...--",
    "....-", ".....", "-....", "--...", "---..", "----."
  };
  string glyphs = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  always #5 clk = ~clk;

  morse_char_assembler #(
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .symbol       (symbol),
    .symbol_count (symbol_count),
    .lg           (lg),
    .wg           (wg),
    .char_data    (char_data),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  function automatic logic [7:0] ref_char(int cnt, logic [4:0] sym);
    string s;
    string d;
    logic [7:0] r;
    s = "";
    for (int i = 1; i <= cnt; i++) begin
      d = sym[cnt-i] ? "-" : ".";
      s = {s, d};
    end
    r = 8'h3F;
    for (int k = 0; k < 36; k++)
      if (codes[k] == s) r = glyphs[k];
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) char_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic model_gap(int cnt, logic [4:0] sym, bit is_wg);
    if (is_wg) begin
      if (cnt != 0) q.push_back(ref_char(cnt, sym));
      if (cnt != 0 || !last_space) q.push_back(8'h20);
      last_space = 1'b1;
    end else if (cnt != 0) begin
      q.push_back(ref_char(cnt, sym));
      last_space = 1'b0;
    end
  endtask

  // Pattern held one cycle, then cleared together with the gap pulse.
  task automatic send(int cnt, logic [4:0] sym, bit is_wg, bit both);
    symbol       = sym;
    symbol_count = cnt[2:0];
    tick();
    symbol       = '0;
    symbol_count = '0;
    wg = is_wg;
    lg = !is_wg || both;
    tick();
    lg = 1'b0;
    wg = 1'b0;
    model_gap(cnt, sym, is_wg);
  endtask

  task automatic pop_expect(string tag, logic [7:0] exp);
    check({tag, "_valid"}, char_valid, 1);
    check({tag, "_data"}, char_data, exp);
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    last_space = 1'b1;
    q.delete();
  endtask

  task automatic rand_letter(output int cnt, output logic [4:0] sym);
    logic [4:0] m;
    cnt = $urandom_range(1, 5);
    m   = 5'((1 << cnt) - 1);
    sym = 5'($urandom) & m;
  endtask

  always @(negedge clk) begin
    if (mon_en && char_valid && char_ready) begin
      check("pop_expected", q.size() != 0, 1);
      if (q.size() != 0) check("rand_data", char_data, q.pop_front());
    end
  end

  initial begin
    int cnt;
    int waited;
    logic [4:0] sym;
    logic [4:0] m;
    int r;

    do_reset();
    check("rst_valid", char_valid, 0);
    check("rst_data", char_data, 8'h00);
    check("rst_ovf", overflow, 0);
    check("rst_level", fifo_level, 0);

    send(2, 5'b01, 1'b0, 1'b0);
    check("a_lat1_valid", char_valid, 0);
    tick();
    check("a_valid", char_valid, 1);
    check("a_data", char_data, 8'h41);
    check("a_level", fifo_level, 1);
    pop_expect("a_pop", 8'h41);
    check("a_empty", fifo_level, 0);

    send(3, 5'b000, 1'b0, 1'b0);
    send(3, 5'b111, 1'b0, 1'b0);
    send(3, 5'b000, 1'b0, 1'b0);
    send(0, 5'b0, 1'b1, 1'b0);
    tick();
    tick();
    check("sos_level", fifo_level, 4);
    send(0, 5'b0, 1'b1, 1'b0);
    tick();
    tick();
    check("sos_wg2_level", fifo_level, 4);
    pop_expect("sos0", 8'h53);
    pop_expect("sos1", 8'h4F);
    pop_expect("sos2", 8'h53);
    pop_expect("sos3", 8'h20);
    check("sos_drained", char_valid, 0);

    send(3, 5'b010, 1'b1, 1'b0);
    tick();
    check("r_data", char_data, 8'h52);
    check("r_level", fifo_level, 1);
    tick();
    check("r_sp_level", fifo_level, 2);
    tick();
    send(4, 5'b1111, 1'b0, 1'b0);
    tick();
    check("unk_level", fifo_level, 3);
    pop_expect("r0", 8'h52);
    pop_expect("r1", 8'h20);
    pop_expect("r2", 8'h3F);

    for (int i = 0; i <= DEPTH; i++) begin
      rand_letter(cnt, sym);
      exp_c[i] = ref_char(cnt, sym);
      if (i == DEPTH) begin
        check("full_level", fifo_level, DEPTH);
        check("full_no_ovf", overflow, 0);
      end
      send(cnt, sym, 1'b0, 1'b0);
      if (i == DEPTH) check("ovf_before_edge", overflow, 0);
      tick();
    end
    check("ovf_level", fifo_level, DEPTH);
    check("ovf_set", overflow, 1);
    for (int i = 0; i < DEPTH; i++) pop_expect("ovf_drain", exp_c[i]);
    check("ovf_drained", char_valid, 0);

    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      rand_letter(cnt, sym);
      exp_c[i] = ref_char(cnt, sym);
      send(cnt, sym, 1'b0, 1'b0);
      tick();
    end
    check("wp_full", fifo_level, DEPTH);
    rand_letter(cnt, sym);
    exp_c[DEPTH] = ref_char(cnt, sym);
    send(cnt, sym, 1'b0, 1'b0);
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
    check("wp_level", fifo_level, DEPTH);
    check("wp_no_ovf", overflow, 0);
    for (int i = 1; i <= DEPTH; i++) pop_expect("wp_drain", exp_c[i]);
    check("wp_drained", char_valid, 0);

    send(0, 5'b0, 1'b0, 1'b0);
    send(1, 5'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_valid", char_valid, 0);
    check("mid_data", char_data, 8'h00);
    check("mid_ovf", overflow, 0);
    check("mid_level", fifo_level, 0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_after_valid", char_valid, 0);
    check("mid_after_level", fifo_level, 0);
    send(0, 5'b0, 1'b1, 1'b0);
    tick();
    tick();
    check("no_lead_space", char_valid, 0);
    send(2, 5'b01, 1'b1, 1'b1);
    tick();
    tick();
    check("both_level", fifo_level, 2);
    pop_expect("both0", 8'h41);
    pop_expect("both1", 8'h20);

    do_reset();
    mon_en     = 1'b1;
    rand_ready = 1'b1;
    for (int n = 0; n < 80; n++) begin
      waited = 0;
      while (fifo_level > DEPTH - 2 && waited < 100) begin
        tick();
        waited++;
      end
      check("rand_wait_level", waited < 100, 1);
      r   = $urandom_range(0, 9);
      cnt = $urandom_range(0, 5);
      m   = 5'((1 << cnt) - 1);
      sym = 5'($urandom) & m;
      send(cnt, sym, r < 4, r == 3);
      tick();
      tick();
    end
    rand_ready = 1'b0;
    char_ready = 1'b1;
    waited = 0;
    while (q.size() != 0 && waited < 200) begin
      tick();
      waited++;
    end
    tick();
    check("rand_q_empty", q.size(), 0);
    check("rand_valid", char_valid, 0);
    check("rand_level", fifo_level, 0);
    check("rand_ovf", overflow, 0);
    mon_en     = 1'b0;
    char_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_char_assembler.md
# morse_char_assembler

Downstream stage of the Morse element decoder. It captures each completed element pattern (`symbol`, `symbol_count`) when a letter gap or word gap closes it, translates the pattern to ASCII, and inserts a space at word gaps. It queues the resulting characters in a small FIFO and presents them over a valid/ready interface to the display or UART stage.

## Interface
Parameters:
- `DEPTH`, 8: FIFO depth in characters; power of two, minimum 2.
- `AW`, $clog2(DEPTH): FIFO pointer width (derived; do not override).

Ports:
- `clk`  in  1  system clock. One clock domain; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `symbol`  in  5  element pattern. 1 = dash, 0 = dot. The newest element is in bit 0, so element i (first = 1) sits at `symbol[count-i]`.
- `symbol_count`  in  3  number of valid elements, 0..5.
- `lg`  in  1  letter-gap pulse, one cycle wide.
- `wg`  in  1  word-gap pulse, one cycle wide.
- `char_data`  out  8  ASCII character at the FIFO head.
- `char_valid`  out  1  FIFO not empty.
- `char_ready`  in  1  consumer accepts `char_data` this cycle.
- `overflow`  out  1  sticky; set when a character is dropped because the FIFO is full.
- `fifo_level`  out  AW+1  current FIFO occupancy.

## Operation
- **Shadow capture.** The upstream clears `symbol`/`symbol_count` in the same cycle that `lg` or `wg` is high. The block therefore registers `symbol` and `symbol_count` every cycle into a shadow (`sh_sym`, `sh_cnt`) and decodes from the shadow, never from the live inputs.
- **Lookup** (combinational on the shadow) covers A–Z and 0–9 by the international code. Examples:
  - count 1, 0 → 'E' (0x45); count 1, 1 → 'T'.
  - count 2, 01 → 'A'.
  - count 3, 000 → 'S'; count 3, 111 → 'O'.
  - count 5, 11111 → '0'; count 5, 01111 → '1'; count 5, 00000 → '5'.
  - Any other pattern with count 1..5 → '?' (0x3F).
- **FSM** states and transitions:
  - IDLE, on `lg` with `sh_cnt` ≠ 0: latch the lookup into `pend_char`, go to PUSH_CHAR.
  - IDLE, on `wg` with `sh_cnt` ≠ 0: latch `pend_char`, set `pend_space`, go to PUSH_CHAR.
  - IDLE, on `wg` with `sh_cnt` = 0: go to PUSH_SPACE if `last_was_space` = 0, otherwise stay in IDLE.
  - IDLE, on `lg` with `sh_cnt` = 0: ignored.
  - `lg` and `wg` high in the same cycle: treated as `wg`.
  - PUSH_CHAR: write `pend_char`; go to PUSH_SPACE if `pend_space` is set, else IDLE.
  - PUSH_SPACE: write 0x20; go to IDLE.
  - Gap pulses arriving outside IDLE are ignored. The upstream gap spacing (hundreds of cycles) makes this unreachable in normal use.
- **`last_was_space`**: set by a space write, cleared by a character write; reset value 1, so no leading space.
- **FIFO**: first-word-fall-through.
  - A write when full is dropped and sets `overflow`. The FSM still advances.
  - Pop occurs when `char_valid` && `char_ready`.
  - Simultaneous write and pop when full: the pop frees a slot, the write succeeds, and the level is unchanged.
  - Simultaneous write and pop when empty: the write lands and `char_valid` rises the next cycle; nothing pops.
  - Pointers wrap modulo DEPTH. `fifo_level` runs 0..DEPTH.
- **Reset** (any time, including mid-push): FSM to IDLE, pointers and level to 0, `char_valid`=0, `char_data`=0x00, `overflow`=0, shadow registers 0, `last_was_space`=1. A partial letter in flight is lost.

## Timing
- The gap pulse is sampled at edge N; the FSM is in PUSH_CHAR after N.
- The character is written at edge N+1. `char_valid`/`char_data` are valid after N+1 (latency 2 from the pulse edge).
- The word-gap space is written at edge N+2.
- Pop takes effect at the edge where `char_valid`&&`char_ready`; the next entry appears after that edge.
- `overflow` rises at the edge of the dropped write.

## Structure
- Package `morse_pkg`:
  - ASCII constants `CH_SPACE`=0x20 and `CH_UNKNOWN`=0x3F.
  - FSM state enum (IDLE, PUSH_CHAR, PUSH_SPACE).
  - Function `morse_lookup(cnt[2:0], sym[4:0]) → [7:0]`.
- Sub-module `morse_char_fifo`: parameter DEPTH; ports wr_en, wr_data, rd_en, rd_data, empty, full, level. The top holds the shadow registers, FSM, and overflow flag.

## Test plan
- Drive count 2/01, pulse `lg`, hold `char_ready`=0 → `char_valid` rises 2 cycles later with 0x41, `fifo_level`=1.
- Sequence S, O, S (000, 111, 000), each closed by `lg`, then `wg` with count 0 → FIFO holds 0x53 0x4F 0x53 0x20. A second `wg` adds nothing.
- Count 3/010 followed by `wg` → 0x52 then 0x20 on consecutive cycles. Count 4/1111 followed by `lg` → 0x3F.
- `char_ready`=0, push DEPTH+1 letters → `fifo_level`=DEPTH, `overflow`=1, and the first DEPTH characters drain in order.
- FIFO full with `char_ready`=1 while a push lands → level stays DEPTH and no overflow. Assert `reset_n` low in PUSH_CHAR → all outputs return to reset values and no character appears after release.
